imem_loader: RTL and testbench

Boot loader that receives a program as a byte stream over a valid/ready handshake and writes it, word by word, into the instruction memory write port, while holding the processor core in reset. It is the writer side of instruction memory; the fetch stage is the reader. Loading completes with `Done` high, after which the core is released from reset.

---
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed program into instruction memory while holding the core in reset.
// Optional trailing XOR checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        WrEn,
    output logic [31:0] WrAddr,
    output logic [31:0] WrData,
    output logic        CoreRst,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK  = 3'd4,
`endif
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] k_q, k_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] shift_q, shift_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    logic        accept;
    logic        go;
    logic [15:0] n_full;
    state_e      after_payload;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    always_comb begin
        ByteReady = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_DATA: ByteReady = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                  ByteReady = 1'b1;
`endif
            default:                ByteReady = 1'b0;
        endcase
    end

    assign accept = ByteValid && ByteReady;
    assign go     = Start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign n_full = {cnt_q[15:8], ByteIn};

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign after_payload = S_CHK;
`else
    assign after_payload = S_DONE;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif

        case (state_q)
            S_HDR0: if (accept) begin
                cnt_d[15:8] = ByteIn;
                state_d     = S_HDR1;
            end
            S_HDR1: if (accept) begin
                cnt_d = n_full;
                if (32'(n_full) > MAX_WORDS) state_d = S_ERR;
                else if (n_full == 16'd0)    state_d = after_payload;
                else                         state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                shift_d = {shift_q[15:0], ByteIn};
                bcnt_d  = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_d   = xor_q ^ ByteIn;
`endif
                if (bcnt_q == 2'd3) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + {14'd0, k_q, 2'b00};
                    wr_data_d = {shift_q, ByteIn};
                    k_d       = k_q + 16'd1;
                    if (k_q == cnt_q - 16'd1) state_d = after_payload;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: if (accept) begin
                state_d = (ByteIn == xor_q) ? S_DONE : S_ERR;
            end
`endif
            S_IDLE, S_DONE, S_ERR: ;
            default: state_d = S_IDLE;
        endcase

        // A new load always starts from clean counters, whichever idle-like state it leaves.
        if (go) begin
            state_d = S_HDR0;
            cnt_d   = '0;
            k_d     = '0;
            bcnt_d  = '0;
            shift_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
        end
    end

    assign WrEn    = wr_en_q;
    assign WrAddr  = wr_addr_q;
    assign WrData  = wr_data_q;
    assign Done    = (state_q == S_DONE);
    assign Error   = (state_q == S_ERR);
    assign CoreRst = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven streams, hand sequences and randomized loads
// checked against a stream-level reference model. Adapts to IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam int MAXW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        Clk = 1'b0;
    logic        Reset, Start, ByteValid;
    logic [7:0]  ByteIn;
    logic        ByteReady, WrEn, CoreRst, Done, Error;
    logic [31:0] WrAddr, WrData;

    always #5 Clk = ~Clk;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
        .ByteReady(ByteReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .CoreRst(CoreRst), .Done(Done), .Error(Error)
    );

    typedef struct {
        string             name;
        int                len;
        logic [0:15][7:0]  b;
        int                gap;
        bit                d;
        bit                e;
        int                nwr;
        logic [31:0]       lastd;
    } vec_t;

    int          ncmp = 0;
    int          nfail = 0;
    logic [63:0] got_wr[$];
    logic [63:0] exp_wr[$];
    logic [7:0]  strm[$];
    bit          exp_done, exp_err;
    vec_t        vecs[$];

    always @(negedge Clk) if (WrEn === 1'b1) got_wr.push_back({WrAddr, WrData});

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: decode the stream straight from its format rules.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_wr.delete();
        exp_done = 0;
        exp_err  = 0;
        n = int'({strm[0], strm[1]});
        if (n > MAXW) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_wr.push_back({BASE + 32'(4 * i),
                              strm[2+4*i], strm[3+4*i], strm[4+4*i], strm[5+4*i]});
        if (CK == 1) begin
            x = 8'h00;
            for (int i = 2; i < 2 + 4 * n; i++) x ^= strm[i];
            if (strm.size() > 2 + 4 * n && strm[2+4*n] == x) exp_done = 1;
            else exp_err = 1;
        end else begin
            exp_done = 1;
        end
    endtask

    task automatic do_start();
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        chk("start_corerst", CoreRst, 1);
        chk("start_done", Done, 0);
        chk("start_error", Error, 0);
        chk("start_ready", ByteReady, 1);
        got_wr.delete();
    endtask

    // gap: 0 none, 1 idle cycle before every byte, 2 random idle cycles
    task automatic send(int gap);
        int t;
        for (int i = 0; i < strm.size(); i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                @(negedge Clk);
                ByteValid = 1'b0;
                ByteIn    = 8'($urandom);
            end
            @(negedge Clk);
            ByteValid = 1'b1;
            ByteIn    = strm[i];
            #1;
            t = 0;
            while (!ByteReady && t < 50) begin
                @(negedge Clk);
                #1;
                t++;
            end
            if (!ByteReady) begin
                chk("byte_ready_timeout", 0, 1);
                ByteValid = 1'b0;
                return;
            end
            @(posedge Clk);
        end
        @(negedge Clk) ByteValid = 1'b0;
    endtask

    // Called at the first falling edge after the last accepted byte.
    task automatic finish_check(string nm, bit ed, bit ee);
        chk({nm, "_done"}, Done, ed);
        chk({nm, "_error"}, Error, ee);
        chk({nm, "_corerst"}, CoreRst, !ed);
        chk({nm, "_ready_off"}, ByteReady, 0);
        chk({nm, "_last_wren"}, WrEn, (CK == 0 && exp_wr.size() > 0) ? 1 : 0);
        @(negedge Clk);
        chk({nm, "_nwrites"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk({nm, "_write"}, got_wr[i], exp_wr[i]);
        if (exp_wr.size() > 0) begin
            chk({nm, "_addr_hold"}, WrAddr, exp_wr[exp_wr.size()-1][63:32]);
            chk({nm, "_data_hold"}, WrData, exp_wr[exp_wr.size()-1][31:0]);
        end
    endtask

    function automatic vec_t mk(string nm, int len, logic [127:0] b, int gap, bit d, bit e,
                                int nwr, logic [31:0] ld);
        vec_t v;
        v.name = nm; v.len = len; v.b = b; v.gap = gap;
        v.d = d; v.e = e; v.nwr = nwr; v.lastd = ld;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] x;
        Reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
        repeat (2) @(negedge Clk);
        chk("rst_ready", ByteReady, 0);
        chk("rst_wren", WrEn, 0);
        chk("rst_addr", WrAddr, 0);
        chk("rst_data", WrData, 0);
        chk("rst_corerst", CoreRst, 1);
        chk("rst_done", Done, 0);
        chk("rst_error", Error, 0);
        Reset = 1'b0;

        vecs.push_back(mk("single", 6 + CK, 128'h0001_2008_0005_2D00_0000_0000_0000_0000,
                          0, 1, 0, 1, 32'h2008_0005));
        if (CK == 1)
            vecs.push_back(mk("bad_chk", 7, 128'h0001_2008_0005_2C00_0000_0000_0000_0000,
                              0, 0, 1, 1, 32'h2008_0005));
        vecs.push_back(mk("oversize", 2, 128'h0101_0000_0000_0000_0000_0000_0000_0000,
                          0, 0, 1, 0, 32'h0));
        vecs.push_back(mk("three_gap", 14 + CK, 128'h0003_1122_3344_5566_7788_99AA_BBCC_CC00,
                          1, 1, 0, 3, 32'h99AA_BBCC));
        vecs.push_back(mk("three_nogap", 14 + CK, 128'h0003_1122_3344_5566_7788_99AA_BBCC_CC00,
                          0, 1, 0, 3, 32'h99AA_BBCC));
        vecs.push_back(mk("n_zero", 2 + CK, 128'h0, 0, 1, 0, 0, 32'h0));

        foreach (vecs[v]) begin
            strm.delete();
            for (int i = 0; i < vecs[v].len; i++) strm.push_back(vecs[v].b[i]);
            model();
            do_start();
            send(vecs[v].gap);
            finish_check(vecs[v].name, vecs[v].d, vecs[v].e);
            chk({vecs[v].name, "_tbl_nwr"}, got_wr.size(), vecs[v].nwr);
            if (vecs[v].nwr > 0 && got_wr.size() > 0)
                chk({vecs[v].name, "_tbl_lastd"}, got_wr[got_wr.size()-1][31:0], vecs[v].lastd);
        end

        // Reset in the middle of word 1: only word 0 lands, core stays in reset.
        do_start();
        strm = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
        send(0);
        Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        chk("midrst_corerst", CoreRst, 1);
        chk("midrst_ready", ByteReady, 0);
        chk("midrst_wren0", WrEn, 0);
        chk("midrst_done", Done, 0);
        @(negedge Clk);
        chk("midrst_wren1", WrEn, 0);
        chk("midrst_nwrites", got_wr.size(), 1);
        if (got_wr.size() > 0) chk("midrst_word0", got_wr[0], {BASE, 32'hDEAD_BEEF});
        strm = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
        if (CK == 1) strm.push_back(8'h2D);
        model();
        do_start();
        send(0);
        finish_check("after_rst", 1, 0);

        // Largest legal count.
        strm = '{8'h01, 8'h00};
        x = 8'h00;
        for (int i = 0; i < 4 * MAXW; i++) begin
            strm.push_back(8'($urandom));
            x ^= strm[strm.size()-1];
        end
        if (CK == 1) strm.push_back(x);
        model();
        do_start();
        send(0);
        finish_check("max_words", 1, 0);

        for (int it = 0; it < 25; it++) begin
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 65535))
                                            : int'($urandom_range(0, 6));
            strm = '{8'(n >> 8), 8'(n)};
            x = 8'h00;
            if (n <= MAXW) begin
                for (int i = 0; i < 4 * n; i++) begin
                    strm.push_back(8'($urandom));
                    x ^= strm[strm.size()-1];
                end
                if (CK == 1)
                    strm.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
            end
            model();
            do_start();
            send(int'($urandom_range(0, 2)));
            finish_check("random", exp_done, exp_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
